// File: rtl/quant_pkg.sv
// ----------------------------------------------------------------------------
// quant_pkg
//   Shared constants and helpers for the int32 -> int8 requantization path.
//   Holds the fixed-point nudge values used by the rounding doubling-high
//   multiply, the int32 saturation bounds, the legal shift window, and the
//   helper functions that saturate a left shift and clamp a shift amount.
// ----------------------------------------------------------------------------
package quant_pkg;

    localparam int SHIFT_W = 6;

    localparam logic signed [63:0] NUDGE_POS = 64'sh40000000;
    localparam logic signed [63:0] NUDGE_NEG = -(64'sh3FFFFFFF);

    localparam logic signed [31:0] INT32_MIN = 32'sh80000000;
    localparam logic signed [31:0] INT32_MAX = 32'sh7FFFFFFF;

    localparam logic signed [63:0] WIDE_INT32_MIN = -64'sd2147483648;
    localparam logic signed [63:0] WIDE_INT32_MAX = 64'sd2147483647;

    // Shift amounts outside this window are pulled back inside it, so a
    // stray encoding never produces an out-of-range shifter control.
    localparam logic signed [SHIFT_W-1:0] SHIFT_MIN = -6'sd31;
    localparam logic signed [SHIFT_W-1:0] SHIFT_MAX = 6'sd30;

    // x << ls, saturated to the int32 range instead of wrapping.
    function automatic logic signed [31:0] sat_shl32(input logic signed [31:0] x,
                                                     input logic [4:0]         ls);
        logic signed [63:0] wide;
        wide = $signed({{32{x[31]}}, x}) <<< ls;
        if (wide > WIDE_INT32_MAX)
            return INT32_MAX;
        else if (wide < WIDE_INT32_MIN)
            return INT32_MIN;
        else
            return wide[31:0];
    endfunction

    function automatic logic signed [SHIFT_W-1:0] clamp_shift(input logic signed [SHIFT_W-1:0] s);
        if (s < SHIFT_MIN)
            return SHIFT_MIN;
        else if (s > SHIFT_MAX)
            return SHIFT_MAX;
        else
            return s;
    endfunction

endpackage

// File: rtl/requant_lane.sv
// ----------------------------------------------------------------------------
// requant_lane
//   One lane of the four-stage requantizer datapath:
//     S1  saturating left shift, 32x32 signed product, right-shift amount
//     S2  saturating rounding doubling high multiply (SRDHM)
//     S3  rounding divide by power of two
//     S4  add output zero point, clamp, truncate to OUT_W
//   Every stage register loads on the shared advance enable from the top.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   adv               pipeline advance enable (global stall when low)
//   acc               signed int32 accumulator
//   mult              signed Q31 multiplier
//   shift             signed shift, >0 left, <0 right
//   out_offset        signed output zero point
//   act_min/act_max   signed output clamp bounds
//   out_lane          requantized OUT_W result (S4 register)
// ----------------------------------------------------------------------------
module requant_lane
    import quant_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    input  logic [31:0]        acc,
    input  logic [31:0]        mult,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [15:0]        out_offset,
    input  logic [OUT_W-1:0]   act_min,
    input  logic [OUT_W-1:0]   act_max,
    output logic [OUT_W-1:0]   out_lane
);

    // ---------------- S1: shift-left, multiply ----------------
    logic signed [SHIFT_W-1:0] sh_c;
    logic [4:0]                ls_c;
    logic [4:0]                rs_c;
    logic signed [31:0]        x_sat_c;
    logic signed [63:0]        prod_c;
    logic                      ovf_c;

    // NOTE: every always_comb output gets a value on every path (here via the
    // complete if/else); a missed branch would infer a latch.
    always_comb begin
        sh_c = clamp_shift(shift);
        if (sh_c[SHIFT_W-1]) begin
            ls_c = 5'd0;
            rs_c = 5'(-sh_c);
        end else begin
            ls_c = sh_c[4:0];
            rs_c = 5'd0;
        end
        x_sat_c = sat_shl32(acc, ls_c);
        prod_c  = $signed({{32{x_sat_c[31]}}, x_sat_c}) * $signed({{32{mult[31]}}, mult});
        // The one product whose doubled high word overflows int32.
        ovf_c   = (x_sat_c == INT32_MIN) && (mult == INT32_MIN);
    end

    logic signed [63:0] s1_prod;
    logic               s1_ovf;
    logic [4:0]         s1_rs;

    // ---------------- S2: SRDHM ----------------
    logic signed [63:0] sum_c;
    logic signed [63:0] quot_c;
    logic signed [31:0] hi_c;

    always_comb begin
        sum_c  = s1_prod + (s1_prod[63] ? NUDGE_NEG : NUDGE_POS);
        // >>> floors; biasing negatives by 2^31-1 turns that into truncation
        // toward zero, matching C integer division.
        quot_c = sum_c[63] ? ((sum_c + 64'sh7FFFFFFF) >>> 31) : (sum_c >>> 31);
        hi_c   = s1_ovf ? INT32_MAX : quot_c[31:0];
    end

    logic signed [31:0] s2_hi;
    logic [4:0]         s2_rs;

    // ---------------- S3: rounding divide by 2^rs ----------------
    logic [31:0]        mask_c;
    logic [31:0]        rem_c;
    logic [31:0]        thr_c;
    logic signed [31:0] y_c;

    always_comb begin
        mask_c = (32'd1 << s2_rs) - 32'd1;
        rem_c  = s2_hi & mask_c;
        // Negative values need a strictly larger remainder to round up, which
        // gives round-half-away-from-zero.
        thr_c  = (mask_c >> 1) + {31'd0, s2_hi[31]};
        y_c    = (s2_hi >>> s2_rs) + ((rem_c > thr_c) ? 32'sd1 : 32'sd0);
    end

    logic signed [31:0] s3_y;

    // ---------------- S4: offset, clamp ----------------
    logic signed [32:0] z_c;
    logic signed [32:0] min_c;
    logic signed [32:0] max_c;
    logic [OUT_W-1:0]   out_c;

    always_comb begin
        // 33 bits so that int32 extremes plus the offset cannot wrap.
        z_c   = $signed({s3_y[31], s3_y}) + $signed({{17{out_offset[15]}}, out_offset});
        min_c = $signed({{(33-OUT_W){act_min[OUT_W-1]}}, act_min});
        max_c = $signed({{(33-OUT_W){act_max[OUT_W-1]}}, act_max});
        if (z_c < min_c)
            out_c = act_min;
        else if (z_c > max_c)
            out_c = act_max;
        else
            out_c = z_c[OUT_W-1:0];
    end

    // NOTE: the intermediate datapath registers carry no reset; the valid
    // chain in the top qualifies them, so only the visible output is cleared.
    // NOTE: state registers use non-blocking assignment so every stage samples
    // the previous stage's old value on the same edge.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_prod <= prod_c;
            s1_ovf  <= ovf_c;
            s1_rs   <= rs_c;
            s2_hi   <= hi_c;
            s2_rs   <= s1_rs;
            s3_y    <= y_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out_lane <= '0;
        else if (adv)
            out_lane <= out_c;
    end

endmodule

// File: rtl/requant_pipeline.sv
// ----------------------------------------------------------------------------
// requant_pipeline
//   Multi-lane, fully pipelined int32 -> int8 output requantizer. Accepts one
//   vector of LANES accumulators per cycle and produces packed OUT_W results
//   four stages later. A single global stall freezes every stage while the
//   output beat is held and not accepted.
// Ports (NM = PER_CHANNEL ? LANES : 1)
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is combinational from out_ready
//   in_acc            LANES x 32b signed accumulators, lane i at [32i+31:32i]
//   in_mult           NM x 32b signed Q31 multipliers
//   in_shift          NM x 6b signed shifts
//   cfg_out_offset    signed output zero point
//   cfg_act_min/max   signed output clamp bounds
//   out_valid/out_ready output handshake
//   out_data          LANES x OUT_W packed results
// ----------------------------------------------------------------------------
module requant_pipeline
    import quant_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int ACC_W       = 32,
    parameter int OUT_W       = 8,
    parameter int PER_CHANNEL = 0,
    localparam int NM         = (PER_CHANNEL != 0) ? LANES : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ACC_W-1:0] in_acc,
    input  logic [NM*ACC_W-1:0]    in_mult,
    input  logic [NM*SHIFT_W-1:0]  in_shift,
    input  logic [15:0]            cfg_out_offset,
    input  logic [OUT_W-1:0]       cfg_act_min,
    input  logic [OUT_W-1:0]       cfg_act_max,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data
);

    logic [3:0] stage_valid;
    logic       adv;

    // Whole pipe moves together: it only stalls when a held output is refused.
    assign adv       = ~stage_valid[3] | out_ready;
    assign in_ready  = adv;
    assign out_valid = stage_valid[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stage_valid <= '0;
        else if (adv)
            stage_valid <= {stage_valid[2:0], in_valid};
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Broadcast mode feeds every lane from the lane-0 multiplier/shift.
        localparam int MI = (PER_CHANNEL != 0) ? i : 0;

        requant_lane #(
            .OUT_W (OUT_W)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .adv        (adv),
            .acc        (in_acc[ACC_W*i +: ACC_W]),
            .mult       (in_mult[ACC_W*MI +: ACC_W]),
            .shift      (in_shift[SHIFT_W*MI +: SHIFT_W]),
            .out_offset (cfg_out_offset),
            .act_min    (cfg_act_min),
            .act_max    (cfg_act_max),
            .out_lane   (out_data[OUT_W*i +: OUT_W])
        );
    end

endmodule
